// File: rtl/shift_serializer_if.sv
// Load handshake bundle for the shift serializer.
// Master drives the word; slave reports readiness.
interface shift_serializer_if #(
  parameter int WIDTH = 4
);
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_data;
  logic             dir;

  modport master (
    output load_valid,
    output load_data,
    output dir,
    input  load_ready
  );

  modport slave (
    input  load_valid,
    input  load_data,
    input  dir,
    output load_ready
  );
endinterface

// File: rtl/shift_serializer.sv
// Parallel-to-serial transmitter, MSB- or LSB-first,
// each bit held for BIT_CYCLES clocks.
module shift_serializer #(
  parameter int WIDTH      = 4,
  parameter int BIT_CYCLES = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  shift_serializer_if.slave  ld,
  input  logic               fill_in,
  input  logic               abort,
  output logic               sout,
  output logic               sout_valid,
  output logic               busy,
  output logic               done,
  output logic               fill_out
);

  localparam int BW = $clog2(WIDTH);
  localparam int CW = (BIT_CYCLES > 1) ?
                      $clog2(BIT_CYCLES) : 1;

  typedef enum logic {
    S_IDLE,
    S_SHIFT
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_sr;
  logic             r_dir;
  logic [BW-1:0]    r_bit;
  logic [CW-1:0]    r_cyc;
  logic             r_done;
  logic             r_fill;

  logic w_shift;
  logic w_abort;
  logic w_load;
  logic w_pend;
  logic w_last;
  logic w_sbit;

  assign w_shift = (r_state == S_SHIFT);
  assign w_abort = abort & w_shift;
  // abort wins over a same-cycle load request
  assign w_load  = (r_state == S_IDLE) &
                   ld.load_valid & ~abort;
  assign w_pend  = w_shift &
                   (r_cyc == CW'(BIT_CYCLES - 1));
  assign w_last  = w_pend &
                   (r_bit == BW'(WIDTH - 1));
  assign w_sbit  = r_dir ? r_sr[0] : r_sr[WIDTH-1];

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_load) w_next = S_SHIFT;
      S_SHIFT: if (w_abort || w_last) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sr   <= '0;
      r_dir  <= 1'b0;
      r_bit  <= '0;
      r_cyc  <= '0;
      r_done <= 1'b0;
      r_fill <= 1'b0;
    end else begin
      r_done <= w_last & ~w_abort;
      if (w_abort) begin
        r_sr  <= '0;
        r_bit <= '0;
        r_cyc <= '0;
      end else if (w_load) begin
        r_sr  <= ld.load_data;
        r_dir <= ld.dir;
        r_bit <= '0;
        r_cyc <= '0;
      end else if (w_shift) begin
        if (w_pend) begin
          r_cyc  <= '0;
          r_fill <= w_sbit;
          r_sr   <= r_dir ?
                    {fill_in, r_sr[WIDTH-1:1]} :
                    {r_sr[WIDTH-2:0], fill_in};
          r_bit  <= w_last ? '0 : r_bit + 1'b1;
        end else begin
          r_cyc  <= r_cyc + 1'b1;
        end
      end
    end
  end

  assign sout          = w_shift & w_sbit;
  assign sout_valid    = w_shift & (r_cyc == '0);
  assign busy          = w_shift;
  assign done          = r_done;
  assign fill_out      = r_fill;
  assign ld.load_ready = (r_state == S_IDLE);

endmodule

// File: tb/tb_shift_serializer.sv
// Randomized self-checking bench for shift_serializer,
// covering BIT_CYCLES=1 and BIT_CYCLES=3 instances.
module tb_shift_serializer;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         sel = 1'b0;
  logic         lv = 1'b0;
  logic [W-1:0] ldat = '0;
  logic         dr = 1'b0;
  logic         fi = 1'b0;
  logic         ab = 1'b0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  shift_serializer_if #(.WIDTH(W)) if1 ();
  shift_serializer_if #(.WIDTH(W)) if3 ();

  assign if1.load_valid = lv & ~sel;
  assign if3.load_valid = lv & sel;
  assign if1.load_data  = ldat;
  assign if3.load_data  = ldat;
  assign if1.dir        = dr;
  assign if3.dir        = dr;

  logic so1, sv1, bz1, dn1, fo1;
  logic so3, sv3, bz3, dn3, fo3;

  shift_serializer #(.WIDTH(W), .BIT_CYCLES(1)) u1 (
    .clk(clk), .rst_n(rst_n), .ld(if1.slave),
    .fill_in(fi), .abort(ab & ~sel),
    .sout(so1), .sout_valid(sv1), .busy(bz1),
    .done(dn1), .fill_out(fo1)
  );

  shift_serializer #(.WIDTH(W), .BIT_CYCLES(3)) u3 (
    .clk(clk), .rst_n(rst_n), .ld(if3.slave),
    .fill_in(fi), .abort(ab & sel),
    .sout(so3), .sout_valid(sv3), .busy(bz3),
    .done(dn3), .fill_out(fo3)
  );

  // {sout, sout_valid, busy, done, load_ready}
  logic [4:0] obs;
  logic       fo;
  assign obs = sel ?
    {so3, sv3, bz3, dn3, if3.load_ready} :
    {so1, sv1, bz1, dn1, if1.load_ready};
  assign fo = sel ? fo3 : fo1;

  localparam logic [4:0] IDLE_V = 5'b00001;
  localparam logic [4:0] DONE_V = 5'b00011;

  logic [4:0] q[$];

  // Expected per-cycle outputs for one word:
  // bit k of the send order held for b cycles,
  // strobe on the first, then one done cycle.
  task automatic push_word(input logic [W-1:0] w,
                           input logic d, input int b);
    logic bt;
    int   k;
    for (int t = 0; t < W * b; t++) begin
      k  = t / b;
      bt = d ? w[k] : w[W-1-k];
      q.push_back({bt, (t % b) == 0,
                   1'b1, 1'b0, 1'b0});
    end
    q.push_back(DONE_V);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #2;
    checks++;
    if ({so1, sv1, bz1, dn1, fo1,
         so3, sv3, bz3, dn3, fo3} !== 10'b0) begin
      failures++;
      $display("FAIL reset_outs got %b%b%b%b%b %b%b%b%b%b exp 0",
               so1, sv1, bz1, dn1, fo1,
               so3, sv3, bz3, dn3, fo3);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (if1.load_ready !== 1'b1 ||
        if3.load_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready got %b%b exp 11",
               if1.load_ready, if3.load_ready);
    end
  endtask

  task automatic test_word(input logic [W-1:0] w,
                           input logic d,
                           input logic s,
                           input string nm);
    logic [4:0] e;
    logic       lastb;
    int         i;
    sel = s;
    @(negedge clk);
    checks++;
    if (obs !== IDLE_V) begin
      failures++;
      $display("FAIL %s_idle got %b exp %b",
               nm, obs, IDLE_V);
    end
    lastb = d ? w[W-1] : w[0];
    q.delete();
    push_word(w, d, s ? 3 : 1);
    lv = 1'b1; ldat = w; dr = d;
    @(negedge clk);
    lv = 1'b0; ldat = ~w; dr = ~d;
    i = 0;
    while (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL %s cyc%0d got %b exp %b",
                 nm, i, obs, e);
      end
      if (e[1]) begin
        checks++;
        if (fo !== lastb) begin
          failures++;
          $display("FAIL %s_fill_out got %b exp %b",
                   nm, fo, lastb);
        end
      end
      fi = 1'($urandom);
      i++;
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back;
    logic [4:0] e;
    logic [7:0] bits;
    int         n;
    sel = 1'b0;
    @(negedge clk);
    q.delete();
    push_word(4'hA, 1'b0, 1);
    push_word(4'h5, 1'b0, 1);
    lv = 1'b1; ldat = 4'hA; dr = 1'b0;
    @(negedge clk);
    ldat = 4'h5;
    bits = '0;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      e = q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL b2b cyc%0d got %b exp %b",
                 i, obs, e);
      end
      if (obs[3]) begin
        bits = {bits[6:0], obs[4]};
        n++;
      end
      if (i == 5) lv = 1'b0;
      @(negedge clk);
    end
    lv = 1'b0;
    checks++;
    if (bits !== 8'b1010_0101 || n != 8) begin
      failures++;
      $display("FAIL b2b_stream got %b n=%0d exp 10100101 n=8",
               bits, n);
    end
  endtask

  task automatic test_load_ignored;
    logic [4:0]   e;
    logic [W-1:0] w;
    logic         d;
    w = W'($urandom);
    d = 1'($urandom);
    sel = 1'b0;
    @(negedge clk);
    q.delete();
    push_word(w, d, 1);
    lv = 1'b1; ldat = w; dr = d;
    @(negedge clk);
    lv = 1'b0;
    for (int i = 0; i <= W; i++) begin
      e = q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL ign cyc%0d got %b exp %b",
                 i, obs, e);
      end
      lv   = (i == 1);
      ldat = ~w;
      dr   = ~d;
      @(negedge clk);
    end
    lv = 1'b0;
    checks++;
    if (obs !== IDLE_V) begin
      failures++;
      $display("FAIL ign_after got %b exp %b",
               obs, IDLE_V);
    end
  endtask

  task automatic test_abort;
    logic [4:0] e;
    sel = 1'b0;
    @(negedge clk);
    q.delete();
    push_word(4'b1111, 1'b0, 1);
    lv = 1'b1; ldat = 4'b1111; dr = 1'b0;
    @(negedge clk);
    lv = 1'b0;
    for (int i = 0; i < 3; i++) begin
      e = q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL abort cyc%0d got %b exp %b",
                 i, obs, e);
      end
      if (i == 2) ab = 1'b1;
      @(negedge clk);
    end
    ab = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (obs !== IDLE_V) begin
        failures++;
        $display("FAIL abort_idle%0d got %b exp %b",
                 i, obs, IDLE_V);
      end
      @(negedge clk);
    end
    ab = 1'b1; lv = 1'b1; ldat = 4'hF;
    @(negedge clk);
    ab = 1'b0; lv = 1'b0;
    checks++;
    if (obs !== IDLE_V) begin
      failures++;
      $display("FAIL abort_prio got %b exp %b",
               obs, IDLE_V);
    end
  endtask

  task automatic test_reset_mid;
    logic [4:0]   e;
    logic [W-1:0] w;
    w = W'($urandom) | 4'b1000;
    sel = 1'b1;
    @(negedge clk);
    q.delete();
    push_word(w, 1'b0, 3);
    lv = 1'b1; ldat = w; dr = 1'b0;
    @(negedge clk);
    lv = 1'b0;
    for (int i = 0; i < 5; i++) begin
      e = q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL rstmid cyc%0d got %b exp %b",
                 i, obs, e);
      end
      @(negedge clk);
    end
    checks++;
    if (fo !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_fo_pre got %b exp 1", fo);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({obs[4:1], fo} !== 5'b0) begin
      failures++;
      $display("FAIL rstmid_outs got %b%b exp 00000",
               obs[4:1], fo);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== IDLE_V) begin
        failures++;
        $display("FAIL rstmid_idle%0d got %b exp %b",
                 i, obs, IDLE_V);
      end
    end
    q.delete();
  endtask

  task automatic test_random;
    for (int n = 0; n < 8; n++) begin
      test_word(W'($urandom), 1'($urandom),
                1'($urandom), "rand");
    end
  endtask

  initial begin
    test_reset();
    test_word(4'b1011, 1'b0, 1'b0, "msb");
    test_word(4'b1011, 1'b1, 1'b0, "lsb");
    test_word(4'b0110, 1'b0, 1'b1, "slow");
    test_back_to_back();
    test_load_ignored();
    test_abort();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
endmodule
